// File: rtl/alu64.sv
// alu64: registered 64-bit integer ALU with signed status flags.
// Define ALU64_ARITH_SHIFT_EN to make SHIFT_RIGHT sign-filling.
module alu64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [2:0]  funct,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    output logic [63:0] result,
    output logic        overflow,
    output logic        negative,
    output logic        zero,
    output logic        equal,
    output logic        greater,
    output logic        less
);

    localparam logic [2:0] F_SUM = 3'd0;
    localparam logic [2:0] F_SHL = 3'd1;
    localparam logic [2:0] F_SUB = 3'd2;
    localparam logic [2:0] F_LD  = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4;
    localparam logic [2:0] F_SHR = 3'd5;
    localparam logic [2:0] F_NOT = 3'd6;
    localparam logic [2:0] F_AND = 3'd7;

    logic [63:0] sum;
    logic [63:0] diff;
    logic [63:0] shr;
    logic [5:0]  shamt;
    logic [63:0] res;
    logic        ovf;
    logic        sum_ovf;
    logic        sub_ovf;

    assign shamt = b[5:0];
    assign sum   = a + b;
    assign diff  = a - b;

`ifdef ALU64_ARITH_SHIFT_EN
    assign shr = $unsigned($signed(a) >>> shamt);
`else
    assign shr = a >> shamt;
`endif

    // Overflow from operand and result sign bits only.
    assign sum_ovf = (a[63] == b[63]) && (sum[63] != a[63]);
    assign sub_ovf = (a[63] != b[63]) && (diff[63] != a[63]);

    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (funct)
            F_SUM: begin
                res = sum;
                ovf = sum_ovf;
            end
            F_SHL: res = a << shamt;
            F_SUB: begin
                res = diff;
                ovf = sub_ovf;
            end
            F_LD:  res = a;
            F_XOR: res = a ^ b;
            F_SHR: res = shr;
            F_NOT: res = ~a;
            F_AND: res = a & b;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            zero      <= 1'b1;
            equal     <= 1'b1;
            greater   <= 1'b0;
            less      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= res;
                overflow <= ovf;
                negative <= res[63];
                zero     <= (res == '0);
                equal    <= (a == b);
                greater  <= ($signed(a) > $signed(b));
                less     <= ($signed(a) < $signed(b));
            end
        end
    end

endmodule

// File: tb/tb_alu64.sv
// tb_alu64: directed and random checks of alu64 against
// an arithmetic reference model.
module tb_alu64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  funct = '0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic [63:0] result;
    logic        overflow;
    logic        negative;
    logic        zero;
    logic        equal;
    logic        greater;
    logic        less;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_res;
    logic [6:0]  exp_flg;

    alu64 dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .funct(funct),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .result(result),
        .overflow(overflow),
        .negative(negative),
        .zero(zero),
        .equal(equal),
        .greater(greater),
        .less(less)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] flags_now();
        return {out_valid, overflow, negative, zero,
                equal, greater, less};
    endfunction

    // Reference: shifts as multiply/divide by powers of two,
    // overflow as a range check on exact-width signed math.
    task automatic model(input logic [2:0] f,
                         input logic [63:0] x,
                         input logic [63:0] y);
        longint sx, sy;
        logic signed [65:0] wide;
        logic [63:0] p2;
        logic [63:0] r;
        logic        o;
        sx = x;
        sy = y;
        p2 = 64'd1 << y[5:0];
        o = 1'b0;
        wide = '0;
        case (f)
            3'd0: begin
                wide = 66'(sx) + 66'(sy);
                r = x + y;
            end
            3'd1: r = x * p2;
            3'd2: begin
                wide = 66'(sx) - 66'(sy);
                r = x - y;
            end
            3'd3: r = x;
            3'd4: r = x ^ y;
`ifdef ALU64_ARITH_SHIFT_EN
            3'd5: r = x[63] ? ~((~x) / p2) : x / p2;
`else
            3'd5: r = x / p2;
`endif
            3'd6: r = ~x;
            default: r = x & y;
        endcase
        if (f == 3'd0 || f == 3'd2)
            o = (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) ||
                (wide < -66'sh0_8000_0000_0000_0000);
        exp_res = r;
        exp_flg = {1'b1, o, r[63], r == 64'd0,
                   sx == sy, sx > sy, sx < sy};
    endtask

    task automatic issue(input logic [2:0] f,
                         input logic [63:0] x,
                         input logic [63:0] y,
                         input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        funct = f;
        a = x;
        b = y;
        model(f, x, y);
        @(posedge clk);
        #1;
        check({tag, ".res"}, result, exp_res);
        check({tag, ".flg"}, 64'(flags_now()), 64'(exp_flg));
    endtask

    localparam logic [6:0] RST_FLG = 7'b0001100;

    initial begin
        logic [63:0] held;
        logic [6:0]  hflg;
        #12;
        check("rst.res", result, 64'd0);
        check("rst.flg", 64'(flags_now()), 64'(RST_FLG));
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'd0, 64'd12, 64'd25, "sum12");
        check("sum12.lit", result, 64'd37);
        check("sum12.lt", 64'(less), 64'd1);
        issue(3'd2, 64'd12, 64'd25, "sub12");
        check("sub12.lit", result, 64'hFFFF_FFFF_FFFF_FFF3);
        issue(3'd7, 64'd12, 64'd25, "and");
        check("and.lit", result, 64'd8);
        issue(3'd4, 64'd12, 64'd25, "xor");
        check("xor.lit", result, 64'd21);
        issue(3'd6, 64'd0, 64'd99, "not");
        check("not.lit", result, '1);
        issue(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, "sumov");
        check("sumov.lit", result, 64'h8000_0000_0000_0002);
        check("sumov.ov", 64'(overflow), 64'd1);
        issue(3'd2, 64'h8000_0000_0000_0000, 64'd3, "subov");
        check("subov.lit", result, 64'h7FFF_FFFF_FFFF_FFFD);
        check("subov.ov", 64'(overflow), 64'd1);
        issue(3'd2, 64'd54, 64'd54, "subeq");
        check("subeq.z", 64'({zero, equal}), 64'd3);
        issue(3'd5, 64'h8000_0000_0000_0000, 64'd4, "shr");
`ifdef ALU64_ARITH_SHIFT_EN
        check("shr.lit", result, 64'hF800_0000_0000_0000);
`else
        check("shr.lit", result, 64'h0800_0000_0000_0000);
`endif
        issue(3'd1, 64'd1, 64'd67, "shl");
        check("shl.lit", result, 64'd8);
        issue(3'd3, 64'hDEAD_BEEF_0000_0001, 64'd0, "load");
        issue(3'd5, 64'hF000_0000_0000_0001, 64'd64, "shr0");

        // Idle cycles with moving operands must not disturb outputs.
        held = result;
        hflg = flags_now();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            funct = 3'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("hold.res", result, held);
            check("hold.flg", 64'(flags_now()),
                  64'({1'b0, hflg[5:0]}));
        end

        // Reset with an operation in flight.
        @(negedge clk);
        in_valid = 1'b1;
        funct = 3'd0;
        a = 64'd5;
        b = 64'd6;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst.res", result, 64'd0);
        check("mrst.flg", 64'(flags_now()), 64'(RST_FLG));
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post.res", result, 64'd0);
        check("post.flg", 64'(flags_now()), 64'(RST_FLG));

        for (int i = 0; i < 300; i++) begin
            logic [63:0] x, y;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: y = x;
                1: x = 64'h7FFF_FFFF_FFFF_FFFF;
                2: x = 64'h8000_0000_0000_0000;
                3: y = 64'(y[6:0]);
                default: ;
            endcase
            issue(3'($urandom), x, y, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
